// File: rtl/clk_div_pkg.sv
// Shared constants and parameter helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned CNT_W_DEF  = 26;

  // Half-period in source cycles for a 50 % duty output at out_hz.
  function automatic int unsigned hz_to_half(input int unsigned clk_hz,
                                             input int unsigned out_hz);
    return clk_hz / (2 * out_hz);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: half-period counter, output toggle, rise tick and a
// shadowed divide value that only takes effect at a full-period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_HALF = 25_000_000
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             clk_out,
  output logic             tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_half;
  logic [CNT_W-1:0] r_shadow;
  logic             r_pend;
  logic             r_clk;
  logic             r_tick;

  logic [CNT_W-1:0] w_half_m1;
  logic             w_term;
  logic             w_apply;

  assign w_half_m1 = r_half - CNT_W'(1);
  assign w_term    = (r_cnt == w_half_m1);

  // A new ratio may only land where it cannot shorten a phase: while idle,
  // on a realignment, or on the falling edge that closes a full period.
  assign w_apply = r_pend && (sync || !en || (w_term && r_clk));

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_clk    <= 1'b0;
      r_tick   <= 1'b0;
      r_half   <= CNT_W'(DEF_HALF);
      r_shadow <= CNT_W'(DEF_HALF);
      r_pend   <= 1'b0;
    end else begin
      if (sync || !en) begin
        r_cnt  <= '0;
        r_clk  <= 1'b0;
        r_tick <= 1'b0;
      end else if (w_term) begin
        r_cnt  <= '0;
        r_clk  <= !r_clk;
        r_tick <= !r_clk;
      end else begin
        r_cnt  <= r_cnt + CNT_W'(1);
        r_tick <= 1'b0;
      end

      if (w_apply) begin
        r_half <= r_shadow;
        r_pend <= 1'b0;
      end

      // A load on the apply edge stays pending for the next boundary.
      if (load) begin
        r_shadow <= load_val;
        r_pend   <= 1'b1;
      end
    end
  end

  assign clk_out = r_clk;
  assign tick    = r_tick;

endmodule

// File: rtl/clk_div_multi.sv
// N_CH-channel programmable clock-enable divider with load decode and error flag.
// Optional SYNC_ALIGN_EN adds sync_all to phase-align every channel at once.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = CNT_W_DEF,
  parameter int unsigned DEF_HALF = hz_to_half(CLK_HZ_DEF, 1)
) (
  input  logic             clk50m,
  input  logic             rst_n,
`ifdef SYNC_ALIGN_EN
  input  logic             sync_all,
`endif
  input  logic [N_CH-1:0]  en,
  input  logic             div_load,
  input  logic [3:0]       div_ch,
  input  logic [CNT_W-1:0] div_val,
  output logic [N_CH-1:0]  clk_out,
  output logic [N_CH-1:0]  tick,
  output logic             load_err
);

  logic            w_sync;
  logic            w_ch_ok;
  logic            w_load_ok;
  logic [N_CH-1:0] w_load;
  logic            r_load_err;

`ifdef SYNC_ALIGN_EN
  assign w_sync = sync_all;
`else
  assign w_sync = 1'b0;
`endif

  // Widened compare so N_CH=16 accepts every 4-bit index.
  assign w_ch_ok   = ({1'b0, div_ch} < 5'(N_CH));
  assign w_load_ok = div_load && w_ch_ok && (div_val != '0);

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= div_load && !w_load_ok;
    end
  end

  assign load_err = r_load_err;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign w_load[i] = w_load_ok && (div_ch == 4'(i));

    clk_div_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_chan (
      .clk50m   (clk50m),
      .rst_n    (rst_n),
      .en       (en[i]),
      .sync     (w_sync),
      .load     (w_load[i]),
      .load_val (div_val),
      .clk_out  (clk_out[i]),
      .tick     (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (N_CH=4, CNT_W=8, DEF_HALF=5).
module tb_clk_div_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;
  localparam int DEFH  = 5;

  logic             clk50m = 1'b0;
  logic             rst_n;
  logic [N_CH-1:0]  en;
  logic             div_load;
  logic [3:0]       div_ch;
  logic [CNT_W-1:0] div_val;
  logic [N_CH-1:0]  clk_out;
  logic [N_CH-1:0]  tick;
  logic             load_err;
`ifdef SYNC_ALIGN_EN
  logic             sync_all;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  clk_div_multi #(
    .N_CH     (N_CH),
    .CNT_W    (CNT_W),
    .DEF_HALF (DEFH)
  ) dut (
    .clk50m   (clk50m),
    .rst_n    (rst_n),
`ifdef SYNC_ALIGN_EN
    .sync_all (sync_all),
`endif
    .en       (en),
    .div_load (div_load),
    .div_ch   (div_ch),
    .div_val  (div_val),
    .clk_out  (clk_out),
    .tick     (tick),
    .load_err (load_err)
  );

  always #10 clk50m = ~clk50m;

  // Expected {clk_out, tick} j edges after counting starts from cnt=0, clk_out=0.
  function automatic logic [1:0] model(input int j, input int h);
    logic c, t;
    c = ((j / h) % 2) == 1;
    t = (j % (2 * h)) == h;
    return {c, t};
  endfunction

  task automatic step();
    @(posedge clk50m);
    #1;
  endtask

  task automatic do_load(input logic [3:0] ch, input logic [CNT_W-1:0] val);
    div_load = 1'b1;
    div_ch   = ch;
    div_val  = val;
    step();
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = '0; div_load = 1'b0; div_ch = '0; div_val = '0;
`ifdef SYNC_ALIGN_EN
    sync_all = 1'b0;
`endif
    #25;
    n_tests++;
    if ({clk_out, tick, load_err} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0", {clk_out, tick, load_err});
    end
    #6 rst_n = 1'b1;
    step();
    n_tests++;
    if ({clk_out, tick, load_err} !== 9'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle got=%b exp=0", {clk_out, tick, load_err});
    end
  endtask

  task automatic test_enable();
    en = '0; step();
    en = 4'b0001;
    for (int j = 1; j <= 30; j++) begin
      step();
      n_tests++;
      if ({clk_out[0], tick[0]} !== model(j, DEFH)) begin
        n_fail++;
        $display("FAIL enable_ch0 j=%0d got=%b exp=%b", j, {clk_out[0], tick[0]}, model(j, DEFH));
      end
      n_tests++;
      if ({clk_out[3:1], tick[3:1]} !== 6'b0) begin
        n_fail++;
        $display("FAIL enable_others j=%0d got=%b exp=0", j, {clk_out[3:1], tick[3:1]});
      end
    end
  endtask

  task automatic test_disable();
    en = '0; step();
    en = 4'b0001;
    for (int j = 1; j <= 7; j++) step();
    n_tests++;
    if (clk_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL disable_prehigh got=%b exp=1", clk_out[0]);
    end
    en = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if ({clk_out[0], tick[0]} !== 2'b00) begin
        n_fail++;
        $display("FAIL disable_forced k=%0d got=%b exp=00", k, {clk_out[0], tick[0]});
      end
    end
    en = 4'b0001;
    for (int j = 1; j <= 6; j++) begin
      step();
      n_tests++;
      if ({clk_out[0], tick[0]} !== model(j, DEFH)) begin
        n_fail++;
        $display("FAIL reenable j=%0d got=%b exp=%b", j, {clk_out[0], tick[0]}, model(j, DEFH));
      end
    end
  endtask

  task automatic test_load_running();
    logic [1:0] e;
    en = '0; step();
    en = 4'b0001;
    for (int j = 1; j <= 24; j++) begin
      if (j == 7) begin
        div_load = 1'b1; div_ch = 4'd0; div_val = 8'd2;
      end
      step();
      div_load = 1'b0;
      e = (j < 10) ? model(j, DEFH) : model(j - 10, 2);
      n_tests++;
      if ({clk_out[0], tick[0]} !== e) begin
        n_fail++;
        $display("FAIL load_running j=%0d got=%b exp=%b", j, {clk_out[0], tick[0]}, e);
      end
      if (j == 7) begin
        n_tests++;
        if (load_err !== 1'b0) begin
          n_fail++;
          $display("FAIL load_running_err got=%b exp=0", load_err);
        end
      end
    end
    en = '0; step();
    do_load(4'd0, 8'(DEFH));
    step();
  endtask

  task automatic test_load_err();
    en = '0; step();
    do_load(4'd3, 8'd3);
    n_tests++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_load_err got=%b exp=0", load_err);
    end
    step();
    do_load(4'd0, 8'd0);
    n_tests++;
    if (load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_zero_val got=%b exp=1", load_err);
    end
    step();
    n_tests++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_zero_val_clear got=%b exp=0", load_err);
    end
    do_load(4'd7, 8'd1);
    n_tests++;
    if (load_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_bad_ch got=%b exp=1", load_err);
    end
    step();
    n_tests++;
    if (load_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_bad_ch_clear got=%b exp=0", load_err);
    end
    en = 4'b1001;
    for (int j = 1; j <= 12; j++) begin
      step();
      n_tests++;
      if ({clk_out[0], tick[0]} !== model(j, DEFH)) begin
        n_fail++;
        $display("FAIL err_ch0_unchanged j=%0d got=%b exp=%b", j, {clk_out[0], tick[0]}, model(j, DEFH));
      end
      n_tests++;
      if ({clk_out[3], tick[3]} !== model(j, 3)) begin
        n_fail++;
        $display("FAIL err_ch3_h3 j=%0d got=%b exp=%b", j, {clk_out[3], tick[3]}, model(j, 3));
      end
    end
  endtask

  task automatic test_h1();
    en = '0; step();
    do_load(4'd1, 8'd1);
    step();
    en = 4'b0010;
    for (int j = 1; j <= 8; j++) begin
      step();
      n_tests++;
      if ({clk_out[1], tick[1]} !== model(j, 1)) begin
        n_fail++;
        $display("FAIL h1_ch1 j=%0d got=%b exp=%b", j, {clk_out[1], tick[1]}, model(j, 1));
      end
    end
  endtask

  task automatic test_last_write();
    logic [1:0] e;
    en = '0; step();
    en = 4'b0100;
    for (int j = 1; j <= 22; j++) begin
      if (j == 7 || j == 8) begin
        div_load = 1'b1; div_ch = 4'd2; div_val = (j == 7) ? 8'd3 : 8'd4;
      end
      step();
      div_load = 1'b0;
      e = (j < 10) ? model(j, DEFH) : model(j - 10, 4);
      n_tests++;
      if ({clk_out[2], tick[2]} !== e) begin
        n_fail++;
        $display("FAIL last_write j=%0d got=%b exp=%b", j, {clk_out[2], tick[2]}, e);
      end
    end
  endtask

  task automatic test_async_reset();
    en = '0; step();
    en = 4'b1001;
    for (int j = 1; j <= 6; j++) step();
    n_tests++;
    if (clk_out[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_prehigh got=%b exp=1", clk_out[0]);
    end
    do_load(4'd0, 8'd2);
    #5 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({clk_out, tick, load_err} !== 9'b0) begin
      n_fail++;
      $display("FAIL areset_immediate got=%b exp=0", {clk_out, tick, load_err});
    end
    en = '0;
    #2 rst_n = 1'b1;
    step();
    en = 4'b1001;
    for (int j = 1; j <= 12; j++) begin
      step();
      n_tests++;
      if ({clk_out[0], tick[0]} !== model(j, DEFH)) begin
        n_fail++;
        $display("FAIL areset_ch0_def j=%0d got=%b exp=%b", j, {clk_out[0], tick[0]}, model(j, DEFH));
      end
      n_tests++;
      if ({clk_out[3], tick[3]} !== model(j, DEFH)) begin
        n_fail++;
        $display("FAIL areset_ch3_def j=%0d got=%b exp=%b", j, {clk_out[3], tick[3]}, model(j, DEFH));
      end
    end
    en = '0; step();
  endtask

`ifdef SYNC_ALIGN_EN
  task automatic test_sync();
    en = '0; step();
    do_load(4'd0, 8'd4);
    do_load(4'd1, 8'd5);
    step();
    en = 4'b0011;
    for (int j = 1; j <= 7; j++) begin
      if (j == 3) begin
        div_load = 1'b1; div_ch = 4'd0; div_val = 8'd3;
      end
      step();
      div_load = 1'b0;
    end
    sync_all = 1'b1;
    step();
    sync_all = 1'b0;
    n_tests++;
    if ({clk_out[1:0], tick[1:0]} !== 4'b0) begin
      n_fail++;
      $display("FAIL sync_forced got=%b exp=0", {clk_out[1:0], tick[1:0]});
    end
    for (int j = 1; j <= 12; j++) begin
      step();
      n_tests++;
      if ({clk_out[0], tick[0]} !== model(j, 3)) begin
        n_fail++;
        $display("FAIL sync_ch0 j=%0d got=%b exp=%b", j, {clk_out[0], tick[0]}, model(j, 3));
      end
      n_tests++;
      if ({clk_out[1], tick[1]} !== model(j, 5)) begin
        n_fail++;
        $display("FAIL sync_ch1 j=%0d got=%b exp=%b", j, {clk_out[1], tick[1]}, model(j, 5));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_enable();
    test_disable();
    test_load_running();
    test_load_err();
    test_h1();
    test_last_write();
    test_async_reset();
`ifdef SYNC_ALIGN_EN
    test_sync();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parameterised multi-channel clock divider and tick generator, the successor to the fixed 50 MHz-to-1 Hz divider. Each of N_CH channels produces a 50 %-duty divided clock-enable waveform and a one-cycle rising-edge tick. The divide ratio is run-time programmable and changes glitch-free at period boundaries. It sits at the top of the design and feeds slow timebases (LED blink, debounce, display scan) in the clk50m domain.

Parameters:
N_CH, 4, number of independent divider channels (1..16)
CNT_W, 26, width of half-period counter and divide value
DEF_HALF, 25_000_000, reset half-period in clk50m cycles (1 Hz at 50 MHz); must be >= 1 and < 2**CNT_W

Ports:
clk50m  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
en  in  N_CH  per-channel run enable, level
div_load  in  1  one-cycle strobe: write div_val to channel div_ch
div_ch  in  4  target channel index for div_load
div_val  in  CNT_W  new half-period H in clk50m cycles
clk_out  out  N_CH  divided waveform, period 2*H cycles, registered
tick  out  N_CH  one-cycle pulse coincident with each clk_out rising edge, registered
load_err  out  1  one-cycle pulse: rejected div_load

Behaviour:
- Reset (rst_n low, asynchronous): cnt=0, clk_out=0, tick=0, load_err=0, active H=DEF_HALF, pending flag=0 for every channel.
- Per channel, while en=1, every clk50m edge: if cnt==H-1 then cnt<=0 and clk_out toggles, else cnt<=cnt+1.
- tick=1 for exactly the cycle in which clk_out goes 0->1; otherwise 0. Never asserted with en=0.
- Enable: en sampled 1 at edge k (cnt=0) -> first clk_out rise and tick at edge k+H-1 relative to the first counting edge, i.e. H edges after en first sampled high. Period is 2*H cycles; high and low are H cycles each.
- Disable: en sampled 0 -> the same edge forces cnt=0, clk_out=0, tick=0. No partial period is completed.
- Load: div_load sampled 1 with div_ch<N_CH and div_val!=0 -> div_val is written to the channel's shadow register and the pending flag is set.
  - Channel disabled: shadow is applied to active H on the next edge.
  - Channel enabled: shadow is applied on the edge where cnt==H-1 and clk_out==1, i.e. the falling edge that ends a full period. The new ratio starts cleanly at the next low phase.
- A second load while pending overwrites the shadow. Last write wins.
- Rejected load: div_ch>=N_CH or div_val==0 -> no state change; load_err=1 on the following cycle.
- H==1: clk_out toggles every cycle (period 2), tick every 2 cycles.
- Counter never exceeds H-1. Wrap-around is only via the cnt==H-1 compare.
- Channels are fully independent. Simultaneous en change and load on one channel: disable takes effect and the load applies immediately (disabled rule).
- Reset mid-period: asynchronous clear of all state including pending loads; active H returns to DEF_HALF.

Optional Feature:
Macro SYNC_ALIGN_EN.
- Defined: adds input sync_all (1 bit). A sampled 1 forces cnt=0, clk_out=0, tick=0 on all enabled channels at the same edge and applies any pending shadows, so all channels are phase-aligned from that edge. Priority: reset > sync_all > normal count. load_err behaviour is unchanged.
- Undefined: port absent; behaviour exactly as above.

Decomposition:
- Package clk_div_pkg holds:
  - CLK_HZ_DEF=50_000_000
  - default CNT_W
  - function hz_to_half(clk_hz, out_hz) returning clk_hz/(2*out_hz), for parameter computation
- Sub-module clk_div_chan implements one channel: counter, toggle, tick, shadow/pending logic. The top instantiates it N_CH times via generate and holds load decode and load_err.

Test Plan:
- Reset, DEF_HALF=5 override, en=4'b0001 -> clk_out[0] rises after 5 edges, period 10, tick[0] one cycle per rise, other channels stay 0.
- Default parameters: 1 s simulated at 20 ns clock -> exactly one clk_out[0] rise and one tick.
- Channel 0 running H=5; load div_ch=0, div_val=2 mid high phase -> current period completes at 10 cycles, then period 4; no runt pulse.
- div_val=0 or div_ch=7 with N_CH=4 -> load_err pulses one cycle later; H unchanged.
- en deasserted mid-high-phase -> clk_out=0 same edge; re-enable -> rise H edges later.
- rst_n pulled low asynchronously between edges with a pending load -> outputs 0 immediately; after release, H=DEF_HALF. With SYNC_ALIGN_EN, sync_all on channels of H=3 and H=5 -> both rise 3/5 edges later from a common origin.
